sample_fetch_ctrl: RTL and testbench
====================================

SAMPLE_FETCH_CTRL -- requirements
Module: sample_fetch_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 15, RAM word-address width; DATA_W, default 16, sample width; NUM_SAMPLES, default 16, samples per frame (power of two, 2..64); RD_LATENCY, default 2, RAM read latency in cycles (1..4).
REQ-002 SHALL have ports, in this order:
- Clk, input, 1, system clock (50 MHz).
- Reset_n, input, 1, asynchronous active-low reset.
- tick, input, 1, single-cycle frame request.
- ram_base, input, ADDR_W, first address of the sample ring.
- ram_end, input, ADDR_W, last address of the sample ring (inclusive).
- ram_addr, output, ADDR_W, RAM read address.
- ram_rden, output, 1, RAM read enable.
- ram_q, input, DATA_W, RAM read data.
- sample_we, output, 1, sample-bank write strobe.
- sample_idx, output, 6, sample-bank slot index.
- sample_data, output, DATA_W, sample-bank write data.
- frame_valid, output, 1, complete frame ready for the consumer.
- frame_ack, input, 1, consumer has taken the frame.
- busy, output, 1, fetch burst in progress.
- overrun, output, 1, sticky flag: a tick was dropped.

Function
REQ-003 SHALL implement the states IDLE, ISSUE, WAIT, CAPTURE and DONE.
REQ-004 IDLE: when tick=1 and frame_valid=0, the block SHALL go to ISSUE with the slot counter at 0. When tick=1 and frame_valid=1, the tick SHALL be dropped and overrun set.
REQ-005 ISSUE SHALL assert ram_rden=1 with ram_addr equal to the read pointer for one cycle, then go to WAIT.
REQ-006 WAIT SHALL hold ram_rden=1 for RD_LATENCY-1 cycles and then go to CAPTURE. With RD_LATENCY=1, WAIT SHALL be skipped.
REQ-007 CAPTURE SHALL, for one cycle:
- assert sample_we=1;
- drive sample_data equal to ram_q and sample_idx equal to the slot counter;
- advance the read pointer.
REQ-008 From CAPTURE, if the slot counter equals NUM_SAMPLES-1 the block SHALL go to DONE; otherwise it SHALL increment the slot counter and go to ISSUE.
REQ-009 Each sample SHALL take exactly RD_LATENCY+1 cycles. A full frame SHALL take NUM_SAMPLES*(RD_LATENCY+1) cycles from the cycle after the tick is accepted to the DONE entry.
REQ-010 DONE SHALL set frame_valid=1 and go to IDLE on the next cycle.
REQ-011 frame_valid SHALL stay 1 until the cycle after frame_ack=1 is sampled. frame_ack while frame_valid=0 SHALL be ignored.
REQ-012 Simultaneous frame_ack=1 and tick=1 in IDLE with frame_valid=1: frame_valid SHALL clear, the tick SHALL be accepted, and overrun SHALL not be set.
REQ-013 The read pointer SHALL wrap from ram_end to ram_base, and it SHALL persist across frames.
REQ-014 A tick received outside IDLE SHALL be ignored without setting overrun.
REQ-015 busy SHALL be 1 in ISSUE, WAIT and CAPTURE, and 0 in IDLE and DONE.
REQ-016 Outside the states named above, ram_rden and sample_we SHALL be 0.
REQ-017 ram_base and ram_end SHALL be sampled only on reset release and at wrap. Changing them mid-burst SHALL take effect only at the next wrap.
REQ-018 An illegal state encoding SHALL return the block to IDLE on the next cycle.

Reset
REQ-019 Reset_n=0 SHALL immediately force, regardless of Clk:
- state to IDLE;
- read pointer to ram_base;
- slot counter to 0;
- ram_addr to ram_base;
- ram_rden, sample_we, frame_valid, busy and overrun to 0;
- sample_idx and sample_data to 0.
REQ-020 Reset during a burst SHALL abort the burst with no further sample_we pulses. The first tick after release SHALL start at ram_base.

Configuration
REQ-021 With SAMPLE_FETCH_OVERRUN_CNT_EN defined, the block SHALL add the output overrun_cnt[7:0]. This counter SHALL count dropped ticks, saturate at 255 and clear on reset.
REQ-022 Without SAMPLE_FETCH_OVERRUN_CNT_EN, the overrun_cnt port and its logic SHALL be absent, and the sticky overrun flag alone SHALL be kept.

Structure
REQ-023 The state enum type and the default values of ADDR_W, DATA_W, NUM_SAMPLES and RD_LATENCY SHALL live in the shared package sample_fetch_pkg.
REQ-024 The read-pointer ring logic (load, increment, wrap) SHALL be a sub-module named ring_addr_gen. The FSM SHALL remain in sample_fetch_ctrl.

Verification
REQ-025 The bench SHALL cover these scenarios (all at defaults unless stated):
- Basic frame: ram_base=0x0000, ram_end=0x7FFF, RAM[i]=i, one tick -> 16 sample_we pulses, 3 cycles apart, with sample_idx 0..15 and sample_data 0x0000..0x000F; then frame_valid=1 at cycle 48.
- Wrap: ram_base=0x0010, ram_end=0x0017, two frames acked -> frame 1 addresses 0x10..0x17,0x10..0x17; frame 2 continues with the same pattern.
- Overrun: tick with frame_valid=1 and no ack -> tick dropped, overrun=1, no RAM reads. With the macro defined, overrun_cnt=1.
- Ack and tick together: frame_ack=1 and tick=1 in the same cycle -> frame_valid clears, a new burst starts on the next cycle, overrun stays 0.
- Mid-burst reset: Reset_n=0 after sample 5 -> outputs zero immediately; the next tick restarts at ram_base with sample_idx=0.
- RD_LATENCY=1 -> samples 2 cycles apart; frame_valid=1 at cycle 32.

Source files
------------

// File: rtl/sample_fetch_pkg.sv
// Shared types and default parameters for the sample fetch controller.
package sample_fetch_pkg;

  localparam int ADDR_W_DEF      = 15;
  localparam int DATA_W_DEF      = 16;
  localparam int NUM_SAMPLES_DEF = 16;
  localparam int RD_LATENCY_DEF  = 2;
  localparam int IDX_W           = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ring_addr_gen.sv
// Ring read pointer: loads base/end on reset release, increments on advance,
// and wraps from the captured end back to the live base (re-sampling both).
module ring_addr_gen #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ram_base,
  input  logic [ADDR_W-1:0] ram_end,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr
);

  logic              load_pend_q, load_pend_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] cur_ptr, cur_end;

  // Until the first clock after reset the live inputs stand in for the
  // registered copies, so the pointer reads as ram_base during reset.
  always_comb begin
    cur_ptr     = load_pend_q ? ram_base : ptr_q;
    cur_end     = load_pend_q ? ram_end  : end_q;
    ptr_d       = cur_ptr;
    end_d       = cur_end;
    load_pend_d = 1'b0;
    if (advance) begin
      if (cur_ptr == cur_end) begin
        ptr_d = ram_base;
        end_d = ram_end;
      end else begin
        ptr_d = cur_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pend_q <= 1'b1;
      ptr_q       <= '0;
      end_q       <= '0;
    end else begin
      load_pend_q <= load_pend_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
    end
  end

  assign ptr = cur_ptr;

endmodule

// File: rtl/sample_fetch_ctrl.sv
// Frame fetch controller: on tick, reads NUM_SAMPLES words from a RAM ring
// into a sample bank. Optional overrun_cnt output with SAMPLE_FETCH_OVERRUN_CNT_EN.
module sample_fetch_ctrl
  import sample_fetch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int RD_LATENCY  = RD_LATENCY_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              tick,
  input  logic [ADDR_W-1:0] ram_base,
  input  logic [ADDR_W-1:0] ram_end,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              sample_we,
  output logic [IDX_W-1:0]  sample_idx,
  output logic [DATA_W-1:0] sample_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              busy,
  output logic              overrun
`ifdef SAMPLE_FETCH_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_cnt
`endif
);

  localparam logic [IDX_W-1:0] SLOT_LAST = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [1:0]       WAIT_LAST = 2'(RD_LATENCY - 2);

  fetch_state_e     state_q, state_d;
  logic [IDX_W-1:0] slot_q, slot_d;
  logic [1:0]       wait_q, wait_d;
  logic             fv_q, fv_d;
  logic             ovr_q, ovr_d;
  logic             tick_drop;
  logic             advance;

  ring_addr_gen #(.ADDR_W(ADDR_W)) u_ring (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .ram_base (ram_base),
    .ram_end  (ram_end),
    .advance  (advance),
    .ptr      (ram_addr)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    wait_d      = wait_q;
    fv_d        = fv_q;
    tick_drop   = 1'b0;
    advance     = 1'b0;
    ram_rden    = 1'b0;
    sample_we   = 1'b0;
    sample_idx  = '0;
    sample_data = '0;
    busy        = 1'b0;
    if (fv_q && frame_ack) fv_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // An ack in the same cycle frees the bank, so the tick is accepted.
        if (tick) begin
          if (!fv_q || frame_ack) begin
            state_d = ST_ISSUE;
            slot_d  = '0;
          end else begin
            tick_drop = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        ram_rden = 1'b1;
        busy     = 1'b1;
        wait_d   = '0;
        state_d  = (RD_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        ram_rden = 1'b1;
        busy     = 1'b1;
        if (wait_q == WAIT_LAST) state_d = ST_CAPTURE;
        else                     wait_d  = wait_q + 2'd1;
      end
      ST_CAPTURE: begin
        sample_we   = 1'b1;
        sample_idx  = slot_q;
        sample_data = ram_q;
        busy        = 1'b1;
        advance     = 1'b1;
        if (slot_q == SLOT_LAST) begin
          state_d = ST_DONE;
          fv_d    = 1'b1;
        end else begin
          slot_d  = slot_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ovr_d = ovr_q | tick_drop;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      wait_q  <= '0;
      fv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      wait_q  <= wait_d;
      fv_q    <= fv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_valid = fv_q;
  assign overrun     = ovr_q;

`ifdef SAMPLE_FETCH_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (tick_drop && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) ovr_cnt_q <= '0;
    else          ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_sample_fetch_ctrl.sv
// Self-checking bench for sample_fetch_ctrl: two instances (RD_LATENCY 2 and 1)
// checked cycle by cycle against a ring/timing reference model.
module tb_sample_fetch_ctrl;

  localparam int N = 16;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [14:0] ram_base, ram_end;
  logic        tick_s   [2];
  logic        ack_s    [2];
  logic [14:0] addr_o   [2];
  logic        rden_o   [2];
  logic [15:0] ram_q_s  [2];
  logic        we_o     [2];
  logic [5:0]  idx_o    [2];
  logic [15:0] data_o   [2];
  logic        fv_o     [2];
  logic        busy_o   [2];
  logic        ovr_o    [2];
`ifdef SAMPLE_FETCH_OVERRUN_CNT_EN
  logic [7:0]  ocnt_o   [2];
`endif

  logic [15:0] mem [0:32767];
  logic [15:0] pipe0;
  int          errors = 0;
  int          checks = 0;
  logic [14:0] exp_ptr [2];
  logic [14:0] exp_end [2];
  logic        exp_ovr [2];

  always #10 Clk = ~Clk;

  sample_fetch_ctrl dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick_s[0]), .ram_base(ram_base), .ram_end(ram_end),
    .ram_addr(addr_o[0]), .ram_rden(rden_o[0]), .ram_q(ram_q_s[0]), .sample_we(we_o[0]),
    .sample_idx(idx_o[0]), .sample_data(data_o[0]), .frame_valid(fv_o[0]),
    .frame_ack(ack_s[0]), .busy(busy_o[0]), .overrun(ovr_o[0])
`ifdef SAMPLE_FETCH_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt_o[0])
`endif
  );

  sample_fetch_ctrl #(.RD_LATENCY(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick_s[1]), .ram_base(ram_base), .ram_end(ram_end),
    .ram_addr(addr_o[1]), .ram_rden(rden_o[1]), .ram_q(ram_q_s[1]), .sample_we(we_o[1]),
    .sample_idx(idx_o[1]), .sample_data(data_o[1]), .frame_valid(fv_o[1]),
    .frame_ack(ack_s[1]), .busy(busy_o[1]), .overrun(ovr_o[1])
`ifdef SAMPLE_FETCH_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt_o[1])
`endif
  );

  // RAM models: 2-cycle and 1-cycle registered read.
  always @(posedge Clk) begin
    pipe0      <= rden_o[0] ? mem[addr_o[0]] : 16'hDEAD;
    ram_q_s[0] <= pipe0;
    ram_q_s[1] <= rden_o[1] ? mem[addr_o[1]] : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_ptr[i] = ram_base;
      exp_end[i] = ram_end;
      exp_ovr[i] = 1'b0;
    end
  endtask

  task automatic ring_step(input int inst);
    if (exp_ptr[inst] == exp_end[inst]) begin
      exp_ptr[inst] = ram_base;
      exp_end[inst] = ram_end;
    end else begin
      exp_ptr[inst] = exp_ptr[inst] + 15'd1;
    end
  endtask

  task automatic chk_reset(input int inst);
    chk("rst_ctl", 32'({we_o[inst], rden_o[inst], busy_o[inst]}), 32'd0);
    chk("rst_frame_valid", 32'(fv_o[inst]), 32'd0);
    chk("rst_overrun", 32'(ovr_o[inst]), 32'd0);
    chk("rst_idx", 32'(idx_o[inst]), 32'd0);
    chk("rst_data", 32'(data_o[inst]), 32'd0);
    chk("rst_addr", 32'(addr_o[inst]), 32'(ram_base));
`ifdef SAMPLE_FETCH_OVERRUN_CNT_EN
    chk("rst_overrun_cnt", 32'(ocnt_o[inst]), 32'd0);
`endif
  endtask

  task automatic do_reset(input logic [14:0] b, input logic [14:0] e);
    @(negedge Clk);
    ram_base = b;
    ram_end  = e;
    Reset_n  = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    $display("reset released base=%h end=%h", b, e);
  endtask

  // One frame: tick (optionally with ack), then check every cycle up to DONE.
  task automatic run_frame(input int inst, input bit with_ack, input int tick_off,
                           input int chg_off, input int abort_off);
    int  lat, per, total, k, ph;
    bit  busy_e, we_e;
    lat   = (inst == 0) ? 2 : 1;
    per   = lat + 1;
    total = N * per;
    @(negedge Clk);
    tick_s[inst] = 1'b1;
    ack_s[inst]  = with_ack;
    for (int off = 0; off <= total; off++) begin
      @(negedge Clk);
      tick_s[inst] = (off == tick_off);
      ack_s[inst]  = 1'b0;
      if (off == chg_off) begin
        ram_base = 15'($urandom_range(32, 400));
        ram_end  = ram_base + 15'($urandom_range(2, 40));
      end
      k      = off / per;
      ph     = off % per;
      busy_e = (off < total);
      we_e   = busy_e && (ph == lat);
      chk("ctl", 32'({we_o[inst], rden_o[inst], busy_o[inst]}),
          32'({we_e, busy_e && !we_e, busy_e}));
      chk("frame_valid", 32'(fv_o[inst]), 32'(off == total));
      if (busy_e && ph == 0) chk("ram_addr", 32'(addr_o[inst]), 32'(exp_ptr[inst]));
      if (we_e) begin
        chk("sample_idx", 32'(idx_o[inst]), 32'(k));
        chk("sample_data", 32'(data_o[inst]), 32'(mem[exp_ptr[inst]]));
        $display("inst%0d sample idx=%0d addr=%h data=%h", inst, idx_o[inst],
                 exp_ptr[inst], data_o[inst]);
        ring_step(inst);
      end
      if (off == abort_off) begin
        Reset_n      = 1'b0;
        tick_s[inst] = 1'b0;
        #1;
        chk_reset(inst);
        $display("inst%0d burst aborted by reset at cycle %0d", inst, off);
        return;
      end
    end
    tick_s[inst] = 1'b0;
    chk("overrun", 32'(ovr_o[inst]), 32'(exp_ovr[inst]));
    $display("inst%0d frame done, frame_valid=%0b", inst, fv_o[inst]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n  = 1'b0;
    ram_base = '0;
    ram_end  = 15'h7FFF;
    for (int i = 0; i < 2; i++) begin
      tick_s[i] = 1'b0;
      ack_s[i]  = 1'b0;
    end
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i);

    // Basic frame, then ack+tick in the same cycle.
    do_reset(15'h0000, 15'h7FFF);
    run_frame(0, 1'b0, -1, -1, -1);
    run_frame(0, 1'b1, -1, -1, -1);

    // Tick while the frame is still unacked: dropped, sticky overrun.
    @(negedge Clk);
    tick_s[0] = 1'b1;
    @(negedge Clk);
    tick_s[0] = 1'b0;
    exp_ovr[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ovr_ctl", 32'({we_o[0], rden_o[0], busy_o[0]}), 32'd0);
      chk("ovr_frame_valid", 32'(fv_o[0]), 32'd1);
      chk("ovr_flag", 32'(ovr_o[0]), 32'd1);
      @(negedge Clk);
    end
`ifdef SAMPLE_FETCH_OVERRUN_CNT_EN
    chk("overrun_cnt", 32'(ocnt_o[0]), 32'd1);
`endif
    $display("inst0 tick dropped, overrun=%0b", ovr_o[0]);

    // Ack clears frame_valid; a stray ack while idle changes nothing.
    ack_s[0] = 1'b1;
    @(negedge Clk);
    ack_s[0] = 1'b0;
    chk("ack_clear", 32'(fv_o[0]), 32'd0);
    ack_s[0] = 1'b1;
    @(negedge Clk);
    ack_s[0] = 1'b0;
    chk("ack_ignored", 32'(fv_o[0]), 32'd0);
    chk("ack_ignored_ctl", 32'({we_o[0], rden_o[0], busy_o[0]}), 32'd0);

    // Small ring with random contents: two frames, stray tick mid-burst.
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    do_reset(15'h0010, 15'h0017);
    run_frame(0, 1'b0, 7, -1, -1);
    run_frame(0, 1'b1, int'($urandom_range(1, 47)), -1, -1);
    chk("wrap_ptr", 32'(addr_o[0]), 32'h10);

    // New ring bounds take effect at the wrap; reset aborts mid-burst.
    ram_base = 15'($urandom_range(32, 400));
    ram_end  = ram_base + 15'($urandom_range(3, 30));
    run_frame(0, 1'b1, -1, -1, 20);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("reset_no_we", 32'({we_o[0], busy_o[0], fv_o[0]}), 32'd0);
    end
    Reset_n = 1'b1;
    model_reset();
    run_frame(0, 1'b0, -1, -1, -1);

    // Randomized frames with ring bounds changed mid-burst.
    for (int r = 0; r < 3; r++)
      run_frame(0, 1'b1, int'($urandom_range(1, 47)), int'($urandom_range(1, 47)), -1);

    // RD_LATENCY=1 instance.
    run_frame(1, 1'b0, -1, -1, -1);
    run_frame(1, 1'b1, int'($urandom_range(1, 31)), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
